// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder with start/busy/done handshake
//
// Computes a + b + cin one bit per clock, LSB first, with one full-adder
// cell and a carry flip-flop. Latency from an accepted start is WIDTH+1
// edges; back-to-back operations start in the DONE cycle.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed overflow output ovf).
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - operation request, honoured in IDLE or DONE only
//   a, b   - WIDTH-bit operands, latched on the accepted start
//   cin    - carry-in, latched on the accepted start
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/cout (and ovf) are valid
//   sum    - WIDTH-bit result, held until the next result
//   cout   - carry out of the MSB, held like sum
//   ovf    - signed overflow, held like sum (SERIAL_ADDER_OVF_EN only)

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc_sr;
   logic             carry;
   logic [CW-1:0]    bit_cnt;

   logic             accept;
   logic             last_bit;
   logic             s_bit;
   logic             c_nxt;

   // Single full-adder cell working on the operand LSBs.
   assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
   assign c_nxt    = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
   assign last_bit = (bit_cnt == LAST_BIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath. Result registers are written only on the final RUN edge so
   // that sum/cout keep the previous result while a new operation runs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         acc_sr  <= '0;
         carry   <= 1'b0;
         bit_cnt <= '0;
         sum     <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf     <= 1'b0;
`endif
      end else if (accept) begin
         a_sr    <= a;
         b_sr    <= b;
         carry   <= cin;
         bit_cnt <= '0;
      end else if (state == ST_RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         acc_sr <= {s_bit, acc_sr[WIDTH-1:1]};
         carry  <= c_nxt;
         // Counter holds on the last bit so it never wraps when WIDTH is a power of two.
         if (!last_bit) begin
            bit_cnt <= bit_cnt + CW'(1);
         end
         if (last_bit) begin
            sum  <= {s_bit, acc_sr[WIDTH-1:1]};
            cout <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge.
            ovf  <= carry ^ c_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8)

module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width integer addition.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int unsigned t;
      t = int'(x) + int'(y) + int'(c);
      return t[W:0];
   endfunction

   // Reference: signed overflow when the true signed sum leaves [-2^(W-1), 2^(W-1)-1].
   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int t;
      t = int'($signed(x)) + int'($signed(y)) + int'(c);
      return (t > 127) || (t < -128);
   endfunction

   // Drives one start pulse from a negedge and waits (bounded) for done.
   // Returns the number of cycles from the cycle after the accepting edge to
   // the done cycle (-1 on timeout), how many cycles busy was high, whether
   // sum/cout moved before done, and whether busy and done ever coincided.
   // poke_at >= 0 raises start again with other operands in that cycle.
   task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v,
                         input int poke_at,
                         output int lat, output int busy_cycles, output bit moved, output bit overlap);
      logic [W-1:0] prev_sum;
      logic         prev_cout;
      prev_sum  = sum;
      prev_cout = cout;
      start = 1'b1;
      a = a_v;
      b = b_v;
      cin = c_v;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      lat = 0;
      busy_cycles = 0;
      moved = 1'b0;
      overlap = 1'b0;
      while (!done && lat < 30) begin
         if (busy) busy_cycles++;
         if (sum !== prev_sum || cout !== prev_cout) moved = 1'b1;
         if (lat == poke_at) begin
            start = 1'b1;
            a = 8'hAA;
            b = 8'h55;
            cin = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (busy && done) overlap = 1'b1;
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: got %b want 0", ovf);
      end
`endif
   endtask

   task automatic test_basic();
      int lat, bc;
      bit mv, ov;
      run_op(8'h3C, 8'h0F, 1'b0, -1, lat, bc, mv, ov);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
      checks++;
      if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
      checks++;
      if (mv !== 1'b0) begin errors++; $display("FAIL basic_sum_stable: sum/cout changed during RUN"); end
      checks++;
      if ({cout, sum} !== 9'h04B) begin errors++; $display("FAIL basic_result: got cout=%b sum=%h want 0 4b", cout, sum); end
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL basic_busy_done_overlap: both high"); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_wrap();
      int lat, bc;
      bit mv, ov;
      run_op(8'hFF, 8'h01, 1'b0, -1, lat, bc, mv, ov);
      checks++;
      if (lat !== 8 || {cout, sum} !== 9'h100) begin
         errors++;
         $display("FAIL wrap_ff_01: lat=%0d cout=%b sum=%h want 8 1 00", lat, cout, sum);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ff_01_ovf: got %b want 0", ovf); end
`endif
      @(negedge clk);
      run_op(8'h7F, 8'h00, 1'b1, -1, lat, bc, mv, ov);
      checks++;
      if (lat !== 8 || {cout, sum} !== 9'h080) begin
         errors++;
         $display("FAIL wrap_7f_cin: lat=%0d cout=%b sum=%h want 8 0 80", lat, cout, sum);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_7f_cin_ovf: got %b want 1", ovf); end
`endif
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int lat, bc;
      bit mv, ov;
      run_op(8'h10, 8'h20, 1'b0, 3, lat, bc, mv, ov);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL ignored_latency: got %0d want 8", lat); end
      checks++;
      if ({cout, sum} !== 9'h030) begin errors++; $display("FAIL ignored_result: got cout=%b sum=%h want 0 30", cout, sum); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      bit mv, ov;
      run_op(8'h21, 8'h42, 1'b0, -1, lat, bc, mv, ov);
      checks++;
      if (lat !== 8 || {cout, sum} !== 9'h063) begin
         errors++;
         $display("FAIL b2b_first: lat=%0d cout=%b sum=%h want 8 0 63", lat, cout, sum);
      end
      // Issued in the done cycle of the first op: second done is 9 edges later.
      run_op(8'h01, 8'h01, 1'b1, -1, lat, bc, mv, ov);
      checks++;
      if (lat + 1 !== 9) begin errors++; $display("FAIL b2b_spacing: got %0d edges want 9", lat + 1); end
      checks++;
      if ({cout, sum} !== 9'h003) begin errors++; $display("FAIL b2b_second: got cout=%b sum=%h want 0 03", cout, sum); end
      checks++;
      if (mv !== 1'b0) begin errors++; $display("FAIL b2b_hold: previous result changed during RUN"); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, bc, seen;
      bit mv, ov;
      start = 1'b1;
      a = 8'hC3;
      b = 8'h5A;
      cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL midreset_outputs: busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
      end
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: %0d active cycles want 0", seen); end
      run_op(8'h05, 8'h03, 1'b0, -1, lat, bc, mv, ov);
      checks++;
      if (lat !== 8 || {cout, sum} !== 9'h008) begin
         errors++;
         $display("FAIL midreset_next_op: lat=%0d cout=%b sum=%h want 8 0 08", lat, cout, sum);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat, bc;
      bit mv, ov;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   exp;
      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         exp = ref_add(ra, rb, rc);
         run_op(ra, rb, rc, -1, lat, bc, mv, ov);
         checks++;
         if (lat !== 8 || {cout, sum} !== exp || mv !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL random_%0d: a=%h b=%h cin=%b lat=%0d cout=%b sum=%h moved=%b want lat 8 cout=%b sum=%h",
                     i, ra, rb, rc, lat, cout, sum, mv, exp[W], exp[W-1:0]);
         end
`ifdef SERIAL_ADDER_OVF_EN
         checks++;
         if (ovf !== ref_ovf(ra, rb, rc)) begin
            errors++;
            $display("FAIL random_ovf_%0d: got %b want %b", i, ovf, ref_ovf(ra, rb, rc));
         end
`endif
         // Half the time chain straight into the next op from the done cycle.
         if ($urandom_range(1, 0) == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
